instr_fetch_unit: RTL and testbench

//   Fetch stage directly upstream of the accumulator core. Reads sequential
//   8-bit instructions from program memory over a req/ack interface, buffers

---
 rtl/instr_fetch_unit.sv | 195 +++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Fetch stage: sequential program-memory reads over req/ack into a small
// prefetch FIFO, presented to the core with valid/ready and flushed on redirect.
module instr_fetch_unit #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       redirect,
    input  logic [ADDR_W-1:0]          redirect_pc,
    output logic [DATA_W-1:0]          instr_out,
    output logic [ADDR_W-1:0]          instr_pc,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic                       mem_req,
    output logic [ADDR_W-1:0]          mem_addr,
    input  logic                       mem_ack,
    input  logic [DATA_W-1:0]          mem_rdata,
    output logic [$clog2(DEPTH):0]     fifo_level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   fetch_pc_r, fetch_pc_s;
    logic [ADDR_W-1:0]   mem_addr_r, mem_addr_s;
    logic                discard_r, discard_s;
    logic                mem_req_r;
    logic                space_s;
    logic                push_s;
    logic                pop_s;

    logic [ADDR_W-1:0]   pc_mem_r   [DEPTH];
    logic [DATA_W-1:0]   data_mem_r [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_r, wr_ptr_s;
    logic [PTR_W-1:0]    rd_ptr_r, rd_ptr_s;
    logic [LVL_W-1:0]    level_r, level_s;
    logic [ADDR_W-1:0]   head_pc_s, instr_pc_r;
    logic [DATA_W-1:0]   head_data_s, instr_out_r;
    logic                instr_valid_r;

    // Fetch FSM next state: redirect wins; a pending request is never withdrawn.
    always_comb begin
        state_s    = state_r;
        fetch_pc_s = fetch_pc_r;
        mem_addr_s = mem_addr_r;
        discard_s  = discard_r;
        push_s     = 1'b0;
        space_s    = (level_r + LVL_W'(state_r == ST_REQ)) < LVL_W'(DEPTH);
        if (redirect) begin
            fetch_pc_s = redirect_pc;
            if ((state_r == ST_REQ) && !mem_ack) begin
                // Old address stays on the bus; its data is dropped on ack.
                discard_s = 1'b1;
            end else begin
                state_s    = ST_REQ;
                mem_addr_s = redirect_pc;
                discard_s  = 1'b0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (space_s) begin
                        state_s    = ST_REQ;
                        mem_addr_s = fetch_pc_r;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        state_s   = ST_IDLE;
                        discard_s = 1'b0;
                        if (discard_r) begin
                            // fetch_pc already holds the redirect target
                            fetch_pc_s = fetch_pc_r;
                        end else begin
                            push_s     = 1'b1;
                            fetch_pc_s = fetch_pc_r + ADDR_W'(1);
                        end
                    end else begin
                        state_s = ST_REQ;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end
    end

    // Fetch FSM and bus registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            fetch_pc_r <= '0;
            mem_addr_r <= '0;
            discard_r  <= 1'b0;
            mem_req_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            mem_addr_r <= mem_addr_s;
            discard_r  <= discard_s;
            mem_req_r  <= (state_s == ST_REQ);
        end
    end

    // FIFO pointer and level update; a flush overrides push and pop.
    always_comb begin
        pop_s    = (level_r != '0) && instr_ready && !redirect;
        wr_ptr_s = wr_ptr_r;
        rd_ptr_s = rd_ptr_r;
        level_s  = level_r;
        if (redirect) begin
            wr_ptr_s = '0;
            rd_ptr_s = '0;
            level_s  = '0;
        end else begin
            if (push_s) begin
                wr_ptr_s = wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_s = rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   level_s = level_r + LVL_W'(1);
                2'b01:   level_s = level_r - LVL_W'(1);
                default: level_s = level_r;
            endcase
        end
    end

    // Next head entry; the entry being written bypasses the array when it becomes head.
    always_comb begin
        head_pc_s   = '0;
        head_data_s = '0;
        if (level_s == '0) begin
            head_pc_s   = '0;
            head_data_s = '0;
        end else if (push_s && (rd_ptr_s == wr_ptr_r)) begin
            head_pc_s   = mem_addr_r;
            head_data_s = mem_rdata;
        end else begin
            head_pc_s   = pc_mem_r[rd_ptr_s];
            head_data_s = data_mem_r[rd_ptr_s];
        end
    end

    // FIFO storage, pointers and registered head outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem_r[i]   <= '0;
                data_mem_r[i] <= '0;
            end
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            level_r       <= '0;
            instr_valid_r <= 1'b0;
            instr_pc_r    <= '0;
            instr_out_r   <= '0;
        end else begin
            if (push_s) begin
                pc_mem_r[wr_ptr_r]   <= mem_addr_r;
                data_mem_r[wr_ptr_r] <= mem_rdata;
            end
            wr_ptr_r      <= wr_ptr_s;
            rd_ptr_r      <= rd_ptr_s;
            level_r       <= level_s;
            instr_valid_r <= (level_s != '0);
            instr_pc_r    <= head_pc_s;
            instr_out_r   <= head_data_s;
        end
    end

    assign mem_req     = mem_req_r;
    assign mem_addr    = mem_addr_r;
    assign instr_valid = instr_valid_r;
    assign instr_pc    = instr_pc_r;
    assign instr_out   = instr_out_r;
    assign fifo_level  = level_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a behavioural program memory
// whose ack latency is set per scenario.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        redirect = 1'b0;
    logic [7:0]  redirect_pc = 8'h00;
    logic [7:0]  instr_out;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [2:0]  fifo_level;

    int tests_run = 0;
    int tests_failed = 0;
    int ack_delay = 0;
    int wait_cnt = 0;
    logic [15:0] pop_q[$];
    logic [7:0]  ack_q[$];

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(4), .ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .fifo_level(fifo_level)
    );

    function automatic logic [7:0] prog(input logic [7:0] a);
        return {a[3:0], a[7:4]} ^ 8'h3C;
    endfunction

    // Program memory: ack after ack_delay extra cycles of mem_req.
    always @(negedge clk) begin
        if (reset_n && mem_req) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack = 1'b1; mem_rdata = prog(mem_addr); wait_cnt = 0;
            end else begin
                mem_ack = 1'b0; wait_cnt = wait_cnt + 1;
            end
        end else begin
            mem_ack = 1'b0; wait_cnt = 0;
        end
    end

    // Log accepted instructions and completed memory reads at each edge.
    always @(posedge clk) begin
        if (reset_n && instr_valid && instr_ready) pop_q.push_back({instr_pc, instr_out});
        if (reset_n && mem_req && mem_ack) ack_q.push_back(mem_addr);
    end

    task automatic do_reset(input logic rdy, input int dly);
        reset_n = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        instr_ready = rdy; ack_delay = dly;
        repeat (2) @(posedge clk);
        pop_q.delete(); ack_q.delete();
        #1 reset_n = 1'b1;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; instr_ready = 1'b1; ack_delay = 0;
        step(2);
        tests_run++; if (mem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_req: got %0h expected 0", mem_req); end
        tests_run++; if (mem_addr !== 8'h00) begin tests_failed++; $display("FAIL rst_mem_addr: got %0h expected 00", mem_addr); end
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_valid: got %0h expected 0", instr_valid); end
        tests_run++; if (instr_out !== 8'h00) begin tests_failed++; $display("FAIL rst_instr_out: got %0h expected 00", instr_out); end
        tests_run++; if (instr_pc !== 8'h00) begin tests_failed++; $display("FAIL rst_instr_pc: got %0h expected 00", instr_pc); end
        tests_run++; if (fifo_level !== 3'd0) begin tests_failed++; $display("FAIL rst_level: got %0d expected 0", fifo_level); end
    endtask

    task automatic test_sequential;
        logic [15:0] got;
        do_reset(1'b1, 0);
        step(1);
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin tests_failed++; $display("FAIL seq_first_req: got req=%0h addr=%0h expected req=1 addr=00", mem_req, mem_addr); end
        tests_run++; if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL seq_valid_early: got %0h expected 0", instr_valid); end
        step(1);
        tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 8'h00 || instr_out !== prog(8'h00)) begin tests_failed++; $display("FAIL seq_first_valid: got v=%0h pc=%0h d=%0h expected v=1 pc=00 d=%0h", instr_valid, instr_pc, instr_out, prog(8'h00)); end
        step(10);
        for (int i = 0; i < 4; i++) begin
            got = (pop_q.size() > i) ? pop_q[i] : 16'hxxxx;
            tests_run++; if (got !== {8'(i), prog(8'(i))}) begin tests_failed++; $display("FAIL seq_pop%0d: got %04h expected %04h", i, got, {8'(i), prog(8'(i))}); end
        end
    endtask

    task automatic test_back_to_back;
        int cnt;
        do_reset(1'b0, 0);
        cnt = 0;
        while (!(mem_req === 1'b1 && fifo_level === 3'd1) && cnt < 50) begin step(1); cnt++; end
        tests_run++; if (cnt >= 50) begin tests_failed++; $display("FAIL b2b_setup: got timeout expected req with level 1"); end
        instr_ready = 1'b1;
        step(1);
        instr_ready = 1'b0;
        tests_run++; if (fifo_level !== 3'd1) begin tests_failed++; $display("FAIL b2b_level: got %0d expected 1", fifo_level); end
        tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 8'h01 || instr_out !== prog(8'h01)) begin tests_failed++; $display("FAIL b2b_head: got v=%0h pc=%0h d=%0h expected v=1 pc=01 d=%0h", instr_valid, instr_pc, instr_out, prog(8'h01)); end
    endtask

    task automatic test_fill;
        logic [7:0] got;
        do_reset(1'b0, 0);
        step(14);
        tests_run++; if (ack_q.size() != 4) begin tests_failed++; $display("FAIL fill_reqs: got %0d expected 4", ack_q.size()); end
        tests_run++; if (fifo_level !== 3'd4 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL fill_full: got level=%0d req=%0h expected level=4 req=0", fifo_level, mem_req); end
        instr_ready = 1'b1;
        step(1);
        instr_ready = 1'b0;
        tests_run++; if (fifo_level !== 3'd3 || instr_pc !== 8'h01) begin tests_failed++; $display("FAIL fill_pop: got level=%0d pc=%0h expected level=3 pc=01", fifo_level, instr_pc); end
        step(10);
        tests_run++; if (ack_q.size() != 5) begin tests_failed++; $display("FAIL fill_refill_cnt: got %0d expected 5", ack_q.size()); end
        got = (ack_q.size() > 4) ? ack_q[4] : 8'hxx;
        tests_run++; if (got !== 8'h04) begin tests_failed++; $display("FAIL fill_refill_addr: got %0h expected 04", got); end
        tests_run++; if (fifo_level !== 3'd4 || mem_req !== 1'b0) begin tests_failed++; $display("FAIL fill_refull: got level=%0d req=%0h expected level=4 req=0", fifo_level, mem_req); end
    endtask

    task automatic test_redirect_pending;
        int cnt;
        logic [7:0]  got_a;
        logic [15:0] got;
        do_reset(1'b1, 3);
        cnt = 0;
        while (!(mem_req === 1'b1 && mem_addr === 8'h03) && cnt < 100) begin step(1); cnt++; end
        tests_run++; if (cnt >= 100) begin tests_failed++; $display("FAIL rdp_setup: got timeout expected req to 03"); end
        pop_q.delete(); ack_q.delete();
        redirect = 1'b1; redirect_pc = 8'h7A;
        step(1);
        redirect = 1'b0;
        tests_run++; if (instr_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 8'h03) begin tests_failed++; $display("FAIL rdp_hold: got v=%0h req=%0h addr=%0h expected v=0 req=1 addr=03", instr_valid, mem_req, mem_addr); end
        step(30);
        got_a = (ack_q.size() > 1) ? ack_q[1] : 8'hxx;
        tests_run++; if (got_a !== 8'h7A) begin tests_failed++; $display("FAIL rdp_next_req: got %0h expected 7a", got_a); end
        got = (pop_q.size() > 0) ? pop_q[0] : 16'hxxxx;
        tests_run++; if (got !== {8'h7A, prog(8'h7A)}) begin tests_failed++; $display("FAIL rdp_first_pop: got %04h expected %04h", got, {8'h7A, prog(8'h7A)}); end
    endtask

    task automatic test_redirect_ack;
        int cnt;
        logic [15:0] got;
        do_reset(1'b1, 2);
        cnt = 0;
        while (!(mem_req === 1'b1 && mem_addr === 8'h01) && cnt < 100) begin step(1); cnt++; end
        tests_run++; if (cnt >= 100) begin tests_failed++; $display("FAIL rda_setup: got timeout expected req to 01"); end
        step(2);
        pop_q.delete(); ack_q.delete();
        redirect = 1'b1; redirect_pc = 8'h40;
        step(1);
        redirect = 1'b0;
        tests_run++; if (ack_q.size() != 1) begin tests_failed++; $display("FAIL rda_same_cycle: got %0d acks expected 1", ack_q.size()); end
        tests_run++; if (fifo_level !== 3'd0 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL rda_empty: got level=%0d v=%0h expected level=0 v=0", fifo_level, instr_valid); end
        cnt = 0;
        while (mem_req !== 1'b1 && cnt < 20) begin step(1); cnt++; end
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 8'h40) begin tests_failed++; $display("FAIL rda_next_addr: got req=%0h addr=%0h expected req=1 addr=40", mem_req, mem_addr); end
        step(20);
        got = (pop_q.size() > 0) ? pop_q[0] : 16'hxxxx;
        tests_run++; if (got !== {8'h40, prog(8'h40)}) begin tests_failed++; $display("FAIL rda_pop0: got %04h expected %04h", got, {8'h40, prog(8'h40)}); end
        got = (pop_q.size() > 1) ? pop_q[1] : 16'hxxxx;
        tests_run++; if (got !== {8'h41, prog(8'h41)}) begin tests_failed++; $display("FAIL rda_pop1: got %04h expected %04h", got, {8'h41, prog(8'h41)}); end
    endtask

    task automatic test_wrap;
        logic [7:0]  exp_pc;
        logic [15:0] got;
        do_reset(1'b0, 0);
        step(12);
        redirect = 1'b1; redirect_pc = 8'hFE; instr_ready = 1'b1;
        step(1);
        redirect = 1'b0;
        pop_q.delete(); ack_q.delete();
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 8'hFE) begin tests_failed++; $display("FAIL wrap_latency_req: got req=%0h addr=%0h expected req=1 addr=fe", mem_req, mem_addr); end
        tests_run++; if (instr_valid !== 1'b0 || fifo_level !== 3'd0) begin tests_failed++; $display("FAIL wrap_flush: got v=%0h level=%0d expected v=0 level=0", instr_valid, fifo_level); end
        step(1);
        tests_run++; if (instr_valid !== 1'b1 || instr_pc !== 8'hFE) begin tests_failed++; $display("FAIL wrap_latency_valid: got v=%0h pc=%0h expected v=1 pc=fe", instr_valid, instr_pc); end
        step(12);
        for (int i = 0; i < 4; i++) begin
            exp_pc = 8'hFE + 8'(i);
            got = (pop_q.size() > i) ? pop_q[i] : 16'hxxxx;
            tests_run++; if (got !== {exp_pc, prog(exp_pc)}) begin tests_failed++; $display("FAIL wrap_pop%0d: got %04h expected %04h", i, got, {exp_pc, prog(exp_pc)}); end
        end
    endtask

    task automatic test_async_reset;
        int cnt;
        do_reset(1'b0, 3);
        cnt = 0;
        while (!(mem_req === 1'b1 && fifo_level === 3'd2) && cnt < 100) begin step(1); cnt++; end
        tests_run++; if (cnt >= 100) begin tests_failed++; $display("FAIL arst_setup: got timeout expected req with level 2"); end
        #2 reset_n = 1'b0;
        #1;
        tests_run++; if (mem_req !== 1'b0 || fifo_level !== 3'd0 || instr_valid !== 1'b0) begin tests_failed++; $display("FAIL arst_immediate: got req=%0h level=%0d v=%0h expected req=0 level=0 v=0", mem_req, fifo_level, instr_valid); end
        ack_delay = 0;
        step(1);
        reset_n = 1'b1;
        cnt = 0;
        while (mem_req !== 1'b1 && cnt < 20) begin step(1); cnt++; end
        tests_run++; if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin tests_failed++; $display("FAIL arst_restart: got req=%0h addr=%0h expected req=1 addr=00", mem_req, mem_addr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_back_to_back();
        test_fill();
        test_redirect_pending();
        test_redirect_ack();
        test_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
